// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int WORD_BYTES     = 4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    LD_LEN   = 3'd0,
    LD_LOAD  = 3'd1,
    LD_CSUM  = 3'd2,
    LD_DONE  = 3'd3,
    LD_ERROR = 3'd4
  } loader_state_e;

  // Running payload checksum: plain 8-bit sum, wrapping mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer and RX FSM.
// Emits a one-cycle byte_valid per good frame; frame_error is sticky.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
)
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rxd,
  output logic                      byte_valid,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      frame_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  // Start bit is confirmed one cycle past its nominal midpoint so that a
  // low pulse of exactly half a bit is still rejected as a glitch.
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);

  logic                      rxd_meta_r;
  logic                      rxd_sync_r;
  rx_state_e                 state_r;
  rx_state_e                 state_next_s;
  logic [TW-1:0]             timer_r;
  logic                      timer_clr_s;
  logic                      sample_s;
  logic [2:0]                bit_cnt_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic                      byte_valid_r;
  logic [UART_DATA_BITS-1:0] byte_data_r;
  logic                      frame_error_r;

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // RX FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // RX FSM next state, timer restart and data-bit sample strobe.
  always_comb begin
    state_next_s = state_r;
    timer_clr_s  = 1'b0;
    sample_s     = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (!rxd_sync_r) begin
          state_next_s = RX_START;
          timer_clr_s  = 1'b1;
        end else begin
          state_next_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (timer_r == HALF_T) begin
          timer_clr_s = 1'b1;
          if (rxd_sync_r) begin
            state_next_s = RX_IDLE;
          end else begin
            state_next_s = RX_DATA;
          end
        end else begin
          state_next_s = RX_START;
        end
      end
      RX_DATA: begin
        if (timer_r == FULL_T) begin
          timer_clr_s = 1'b1;
          sample_s    = 1'b1;
          if (bit_cnt_r == 3'(UART_DATA_BITS - 1)) begin
            state_next_s = RX_STOP;
          end else begin
            state_next_s = RX_DATA;
          end
        end else begin
          state_next_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (timer_r == FULL_T) begin
          timer_clr_s  = 1'b1;
          state_next_s = RX_IDLE;
        end else begin
          state_next_s = RX_STOP;
        end
      end
      default: begin
        state_next_s = RX_IDLE;
      end
    endcase
  end

  // Bit timer, LSB-first shifter and stop-bit check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_r       <= '0;
      bit_cnt_r     <= 3'd0;
      shift_r       <= '0;
      byte_valid_r  <= 1'b0;
      byte_data_r   <= '0;
      frame_error_r <= 1'b0;
    end else begin
      timer_r      <= timer_clr_s ? '0 : timer_r + TW'(1);
      byte_valid_r <= 1'b0;
      if (state_r == RX_START) begin
        bit_cnt_r <= 3'd0;
      end else if (sample_s) begin
        shift_r   <= {rxd_sync_r, shift_r[UART_DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if ((state_r == RX_STOP) && (timer_r == FULL_T)) begin
        if (rxd_sync_r) begin
          byte_valid_r <= 1'b1;
          byte_data_r  <= shift_r;
        end else begin
          frame_error_r <= 1'b1;
        end
      end
    end
  end

  assign byte_valid  = byte_valid_r;
  assign byte_data   = byte_data_r;
  assign frame_error = frame_error_r;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over UART and writes
// it word by word into program memory, holding the CPU in reset until done.
// Optional macro LOADER_CHECKSUM_EN appends an 8-bit payload checksum byte.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14
)
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rxd,
  output logic                  prog_write_enable,
  output logic [ADDR_WIDTH-1:0] prog_write_address,
  output logic [31:0]           prog_write_data,
  output logic                  load_done,
  output logic                  cpu_reset_n,
  output logic                  frame_error,
  output logic                  checksum_error
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_LOAD = LD_CSUM;
`else
  localparam loader_state_e AFTER_LOAD = LD_DONE;
`endif

  logic                  byte_valid_s;
  logic [7:0]            byte_data_s;
  loader_state_e         ld_state_r;
  loader_state_e         ld_next_s;
  logic [1:0]            byte_idx_r;
  logic [23:0]           asm_r;
  logic [31:0]           word_s;
  logic                  word_last_s;
  logic                  accept_s;
  logic [31:0]           count_n_r;
  logic [31:0]           index_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           data_r;
  logic                  load_done_r;
  logic                  cpu_reset_n_r;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd        (uart_rxd),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .frame_error(frame_error)
  );

  // Little-endian assembly: the newest byte lands in the top lane.
  assign word_s      = {byte_data_s, asm_r};
  assign word_last_s = byte_valid_s && (byte_idx_r == 2'(WORD_BYTES - 1));
  assign accept_s    = byte_valid_s && ((ld_state_r == LD_LEN) || (ld_state_r == LD_LOAD));

  // Loader FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_state_r <= LD_LEN;
    end else begin
      ld_state_r <= ld_next_s;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_r;
  logic       checksum_error_r;

  // Payload checksum accumulation and sticky mismatch flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r            <= 8'd0;
      checksum_error_r <= 1'b0;
    end else begin
      if ((ld_state_r == LD_LOAD) && byte_valid_s) begin
        sum_r <= csum_add(sum_r, byte_data_s);
      end
      if ((ld_state_r == LD_CSUM) && byte_valid_s && (byte_data_s != sum_r)) begin
        checksum_error_r <= 1'b1;
      end
    end
  end

  assign checksum_error = checksum_error_r;
`else
  assign checksum_error = 1'b0;
`endif

  // Loader FSM next state.
  always_comb begin
    ld_next_s = ld_state_r;
    case (ld_state_r)
      LD_LEN: begin
        if (word_last_s) begin
          if (word_s == 32'd0) begin
            ld_next_s = AFTER_LOAD;
          end else begin
            ld_next_s = LD_LOAD;
          end
        end else begin
          ld_next_s = LD_LEN;
        end
      end
      LD_LOAD: begin
        if (word_last_s && ((index_r + 32'd1) == count_n_r)) begin
          ld_next_s = AFTER_LOAD;
        end else begin
          ld_next_s = LD_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CSUM: begin
        if (byte_valid_s) begin
          if (byte_data_s == sum_r) begin
            ld_next_s = LD_DONE;
          end else begin
            ld_next_s = LD_ERROR;
          end
        end else begin
          ld_next_s = LD_CSUM;
        end
      end
      LD_ERROR: begin
        ld_next_s = LD_ERROR;
      end
`endif
      LD_DONE: begin
        ld_next_s = LD_DONE;
      end
      default: begin
        ld_next_s = LD_LEN;
      end
    endcase
  end

  // Byte assembly, word count, write strobe/address/data and done flags.
  // Words past the end of memory are still counted but never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx_r    <= 2'd0;
      asm_r         <= 24'd0;
      count_n_r     <= 32'd0;
      index_r       <= 32'd0;
      we_r          <= 1'b0;
      addr_r        <= '0;
      data_r        <= 32'd0;
      load_done_r   <= 1'b0;
      cpu_reset_n_r <= 1'b0;
    end else begin
      we_r <= 1'b0;
      if (accept_s) begin
        byte_idx_r <= byte_idx_r + 2'd1;
        asm_r      <= word_s[31:8];
      end
      if ((ld_state_r == LD_LEN) && word_last_s) begin
        count_n_r <= word_s;
      end
      if ((ld_state_r == LD_LOAD) && word_last_s) begin
        we_r    <= ((index_r >> (ADDR_WIDTH - 2)) == 32'd0);
        addr_r  <= {index_r[ADDR_WIDTH-3:0], 2'b00};
        data_r  <= word_s;
        index_r <= index_r + 32'd1;
      end
      load_done_r   <= (ld_next_s == LD_DONE);
      cpu_reset_n_r <= load_done_r;
    end
  end

  assign prog_write_enable  = we_r;
  assign prog_write_address = addr_r;
  assign prog_write_data    = data_r;
  assign load_done          = load_done_r;
  assign cpu_reset_n        = cpu_reset_n_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader (CLKS_PER_BIT = 16, ADDR_WIDTH = 6).
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rxd = 1'b1;
  logic          prog_write_enable;
  logic [AW-1:0] prog_write_address;
  logic [31:0]   prog_write_data;
  logic          load_done;
  logic          cpu_reset_n;
  logic          frame_error;
  logic          checksum_error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .uart_rxd          (rxd),
    .prog_write_enable (prog_write_enable),
    .prog_write_address(prog_write_address),
    .prog_write_data   (prog_write_data),
    .load_done         (load_done),
    .cpu_reset_n       (cpu_reset_n),
    .frame_error       (frame_error),
    .checksum_error    (checksum_error)
  );

  typedef struct {
    logic [7:0]    b [4];
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    bit            exp_we;
  } vec_t;

  vec_t vecs [19];

  int         total = 0;
  int         bad = 0;
  logic [7:0] sum_b = 8'd0;
  int         rd_idx = 0;

  // Observed write strobes and load_done/cpu_reset_n timing.
  logic [AW-1:0] wq_addr [$];
  logic [31:0]   wq_data [$];
  int            multi = 0;
  int            rises = 0;
  bit            we_prev = 1'b0;
  bit            ld_prev = 1'b0;
  bit            rise_prev = 1'b0;
  logic          crn_at_rise = 1'b0;
  logic          crn_after = 1'b0;

  // Capture write strobes and the cpu_reset_n release relative to load_done.
  always @(negedge clk) begin
    if (!reset_n) begin
      wq_addr.delete();
      wq_data.delete();
      multi       = 0;
      rises       = 0;
      we_prev     = 1'b0;
      ld_prev     = 1'b0;
      rise_prev   = 1'b0;
      crn_at_rise = 1'b0;
      crn_after   = 1'b0;
    end else begin
      if (prog_write_enable) begin
        wq_addr.push_back(prog_write_address);
        wq_data.push_back(prog_write_data);
        if (we_prev) multi = multi + 1;
      end
      if (rise_prev) crn_after = cpu_reset_n;
      rise_prev = load_done && !ld_prev;
      if (rise_prev) begin
        crn_at_rise = cpu_reset_n;
        rises       = rises + 1;
      end
      we_prev = prog_write_enable;
      ld_prev = load_done;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic send_payload(input logic [7:0] b);
    send_byte(b, 1'b1);
    sum_b = sum_b + b;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rxd     = 1'b1;
    reset_n = 1'b0;
    tick(3);
    check("reset_outputs",
          {21'd0, prog_write_enable, prog_write_address, prog_write_data,
           load_done, cpu_reset_n, frame_error, checksum_error}, 64'd0);
    reset_n = 1'b1;
    tick(2);
    rd_idx = 0;
    sum_b  = 8'd0;
  endtask

  task automatic expect_write(input string name, input bit we,
                              input logic [AW-1:0] addr, input logic [31:0] data);
    if (we) begin
      check({name, "_count"}, 64'(wq_addr.size() - rd_idx), 64'd1);
      if (wq_addr.size() > rd_idx) begin
        check({name, "_addr"}, 64'(wq_addr[rd_idx]), 64'(addr));
        check({name, "_data"}, 64'(wq_data[rd_idx]), 64'(data));
        rd_idx = rd_idx + 1;
      end
    end else begin
      check({name, "_count"}, 64'(wq_addr.size() - rd_idx), 64'd0);
    end
  endtask

  task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum_b, 1'b1);
`endif
    tick(4);
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      for (int j = 0; j < 4; j++) send_payload(vecs[i].b[j]);
      expect_write($sformatf("word%0d", i), vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data);
    end
  endtask

  initial begin
    // Test 1 image: two RISC-V instructions.
    vecs[0].b = '{8'h13, 8'h00, 8'h00, 8'h00};
    vecs[0].exp_addr = 6'h00; vecs[0].exp_data = 32'h00000013; vecs[0].exp_we = 1'b1;
    vecs[1].b = '{8'h93, 8'h80, 8'h10, 8'h00};
    vecs[1].exp_addr = 6'h04; vecs[1].exp_data = 32'h00108093; vecs[1].exp_we = 1'b1;
    // Test 3 image: 17 words, the last one beyond the 64-byte memory.
    for (int k = 0; k < 17; k++) begin
      logic [7:0] kb;
      logic [7:0] kh;
      kb = 8'(k);
      kh = 8'hA0 + kb;
      vecs[2+k].b = '{kb, kh, 8'h5A, 8'hC3};
      vecs[2+k].exp_data = {8'hC3, 8'h5A, kh, kb};
      vecs[2+k].exp_addr = 6'(k * 4);
      vecs[2+k].exp_we   = (k < 16);
    end

    // Test 1: two-word image, done flag and CPU release one cycle later.
    do_reset();
    send_len(32'd2);
    run_vecs(0, 0);
    check("t1_not_done_early", 64'(load_done), 64'd0);
    check("t1_cpu_held", 64'(cpu_reset_n), 64'd0);
    run_vecs(1, 1);
    finish_image();
    check("t1_load_done", 64'(load_done), 64'd1);
    check("t1_done_rises", 64'(rises), 64'd1);
    check("t1_crn_at_rise", 64'(crn_at_rise), 64'd0);
    check("t1_crn_after", 64'(crn_after), 64'd1);
    check("t1_single_strobes", 64'(multi), 64'd0);
    check("t1_frame_error", 64'(frame_error), 64'd0);

    // Test 2: empty image.
    do_reset();
    send_len(32'd0);
    finish_image();
    check("t2_load_done", 64'(load_done), 64'd1);
    check("t2_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
    expect_write("t2_nowrite", 1'b0, 6'h00, 32'd0);

    // Test 3: address overflow suppresses the 17th write.
    do_reset();
    send_len(32'd17);
    run_vecs(2, 18);
    finish_image();
    check("t3_load_done", 64'(load_done), 64'd1);
    check("t3_single_strobes", 64'(multi), 64'd0);
    check("t3_total_writes", 64'(wq_addr.size()), 64'd16);

    // Test 4: glitch rejection and a dropped frame-error byte.
    do_reset();
    send_len(32'd2);
    send_payload(8'h11);
    rxd = 1'b0;
    tick(8);
    rxd = 1'b1;
    tick(32);
    check("t4_glitch_no_frame_error", 64'(frame_error), 64'd0);
    send_byte(8'h77, 1'b0);
    tick(CPB);
    check("t4_frame_error", 64'(frame_error), 64'd1);
    send_payload(8'h22);
    send_payload(8'h33);
    send_payload(8'h44);
    expect_write("t4_w0", 1'b1, 6'h00, 32'h44332211);
    send_payload(8'h55);
    send_payload(8'h66);
    send_payload(8'h77);
    send_payload(8'h88);
    expect_write("t4_w1", 1'b1, 6'h04, 32'h88776655);
    finish_image();
    check("t4_load_done", 64'(load_done), 64'd1);

    // Test 5: reset in the middle of word 2, then a fresh one-word image.
    do_reset();
    send_len(32'd2);
    send_payload(8'h11);
    send_payload(8'h22);
    send_payload(8'h33);
    send_payload(8'h44);
    expect_write("t5_w0", 1'b1, 6'h00, 32'h44332211);
    send_payload(8'h55);
    send_payload(8'h66);
    rxd = 1'b0;
    tick(40);
    do_reset();
    send_len(32'd1);
    send_payload(8'hAA);
    send_payload(8'hBB);
    send_payload(8'hCC);
    send_payload(8'hDD);
    expect_write("t5_fresh", 1'b1, 6'h00, 32'hDDCCBBAA);
    finish_image();
    check("t5_load_done", 64'(load_done), 64'd1);
    check("t5_no_extra_writes", 64'(wq_addr.size()), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: checksum match and mismatch.
    do_reset();
    send_len(32'd1);
    send_payload(8'h01);
    send_payload(8'h02);
    send_payload(8'h03);
    send_payload(8'h04);
    send_byte(8'h0A, 1'b1);
    tick(4);
    check("t6_good_done", 64'(load_done), 64'd1);
    check("t6_good_csum_err", 64'(checksum_error), 64'd0);
    do_reset();
    send_len(32'd1);
    send_payload(8'h01);
    send_payload(8'h02);
    send_payload(8'h03);
    send_payload(8'h04);
    send_byte(8'h0B, 1'b1);
    tick(4);
    check("t6_bad_csum_err", 64'(checksum_error), 64'd1);
    check("t6_bad_done", 64'(load_done), 64'd0);
    check("t6_bad_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
